// File: rtl/ram_sdp.sv
// Simple-dual-port RAM: byte-strobed write port, pipelined read port with backpressure, zero sweep.
// Optional macro RAM_BYPASS_EN: same-address same-cycle read returns write-first data.
module ram_sdp #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned BYTE_WIDTH   = 8,
    parameter int unsigned READ_LATENCY = 1,
    localparam int unsigned AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned LANES       = WIDTH / BYTE_WIDTH
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             clear_start_i,
    output logic             clear_busy_o,
    input  logic             write_valid_i,
    output logic             write_ready_o,
    input  logic [AW-1:0]    write_address_i,
    input  logic [WIDTH-1:0] write_data_i,
    input  logic [LANES-1:0] write_strobe_i,
    input  logic             read_valid_i,
    output logic             read_ready_o,
    input  logic [AW-1:0]    read_address_i,
    output logic             read_data_valid_o,
    output logic [WIDTH-1:0] read_data_o,
    input  logic             read_data_ready_i
);
    localparam int unsigned   Last     = READ_LATENCY - 1;
    localparam logic [AW:0]   DepthW   = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

    typedef enum logic [0:0] {StClear, StIdle} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             rd_valid_q [READ_LATENCY];
    logic [WIDTH-1:0] rd_data_q [READ_LATENCY];
    logic [WIDTH-1:0] rd_word;
    logic             advance, wr_fire, rd_fire, wr_in_range, rd_in_range;

    assign advance       = !(rd_valid_q[Last] && !read_data_ready_i);
    assign write_ready_o = (state_q == StIdle);
    assign read_ready_o  = (state_q == StIdle) && advance;
    assign clear_busy_o  = (state_q == StClear);
    assign wr_fire       = write_valid_i && write_ready_o;
    assign rd_fire       = read_valid_i && read_ready_o;
    assign wr_in_range   = {1'b0, write_address_i} < DepthW;
    assign rd_in_range   = {1'b0, read_address_i} < DepthW;

    assign read_data_valid_o = rd_valid_q[Last];
    assign read_data_o       = rd_valid_q[Last] ? rd_data_q[Last] : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StClear: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastAddr) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            StIdle: begin
                if (clear_start_i) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= StClear;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage is intentionally unreset; the sweep is the only way it gets zeroed.
    always_ff @(posedge clock_i) begin
        if (state_q == StClear) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_fire && wr_in_range) begin
            for (int l = 0; l < LANES; l++) begin
                if (write_strobe_i[l]) begin
                    mem_q[write_address_i][l*BYTE_WIDTH +: BYTE_WIDTH] <=
                        write_data_i[l*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem_q[read_address_i];
        end
`ifdef RAM_BYPASS_EN
        if (wr_fire && wr_in_range && rd_in_range && (write_address_i == read_address_i)) begin
            for (int l = 0; l < LANES; l++) begin
                if (write_strobe_i[l]) begin
                    rd_word[l*BYTE_WIDTH +: BYTE_WIDTH] = write_data_i[l*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
`endif
    end

    // All stages shift together; a stalled output freezes bubbles as well.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                rd_valid_q[i] <= 1'b0;
                rd_data_q[i]  <= '0;
            end
        end else if (advance) begin
            rd_valid_q[0] <= rd_fire;
            rd_data_q[0]  <= rd_word;
            for (int i = 1; i < READ_LATENCY; i++) begin
                rd_valid_q[i] <= rd_valid_q[i-1];
                rd_data_q[i]  <= rd_data_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_ram_sdp.sv
// Bench for ram_sdp: scoreboarded DUT (DEPTH=12, latency 2) plus a directed DUT (DEPTH=16, latency 1).
`timescale 1ns/1ps
module tb_ram_sdp;
    localparam int unsigned D = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clr = 1'b0, busy, wv = 1'b0, wr, rv = 1'b0, rr, rdv, rdr = 1'b1;
    logic [3:0]  wa = '0, ra = '0, ws = '0;
    logic [31:0] wd = '0, rd;

    logic        b_rst_n = 1'b1;
    logic        b_clr = 1'b0, b_busy, b_wv = 1'b0, b_wr, b_rv = 1'b0, b_rr, b_rdv, b_rdr = 1'b1;
    logic [3:0]  b_wa = '0, b_ra = '0, b_ws = '0;
    logic [31:0] b_wd = '0, b_rd;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp_mem [16];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    ram_sdp #(.WIDTH(32), .DEPTH(D), .BYTE_WIDTH(8), .READ_LATENCY(2)) u_dut (
        .clock_i(clk), .reset_ni(rst_n), .clear_start_i(clr), .clear_busy_o(busy),
        .write_valid_i(wv), .write_ready_o(wr), .write_address_i(wa), .write_data_i(wd),
        .write_strobe_i(ws), .read_valid_i(rv), .read_ready_o(rr), .read_address_i(ra),
        .read_data_valid_o(rdv), .read_data_o(rd), .read_data_ready_i(rdr)
    );

    ram_sdp #(.WIDTH(32), .DEPTH(16), .BYTE_WIDTH(8), .READ_LATENCY(1)) u_dut_b (
        .clock_i(clk), .reset_ni(b_rst_n), .clear_start_i(b_clr), .clear_busy_o(b_busy),
        .write_valid_i(b_wv), .write_ready_o(b_wr), .write_address_i(b_wa), .write_data_i(b_wd),
        .write_strobe_i(b_ws), .read_valid_i(b_rv), .read_ready_o(b_rr), .read_address_i(b_ra),
        .read_data_valid_o(b_rdv), .read_data_o(b_rd), .read_data_ready_i(b_rdr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] a);
        logic [31:0] v;
        v = (32'(a) < D) ? exp_mem[a] : 32'h0;
`ifdef RAM_BYPASS_EN
        if (wv && wr && (wa == a) && (32'(a) < D)) begin
            for (int l = 0; l < 4; l++) if (ws[l]) v[l*8 +: 8] = wd[l*8 +: 8];
        end
`endif
        return v;
    endfunction

    // Scoreboard: results popped on handshake, expectations pushed on read accept, model updated.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rdv && rdr) begin
                if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 1);
                else check("sb_data", rd, exp_q.pop_front());
            end
            if (rv && rr) exp_q.push_back(model_read(ra));
            if (wv && wr && (32'(wa) < D)) begin
                for (int l = 0; l < 4; l++) if (ws[l]) exp_mem[wa][l*8 +: 8] = wd[l*8 +: 8];
            end
            if (clr) for (int i = 0; i < 16; i++) exp_mem[i] = 32'h0;
        end else begin
            exp_q.delete();
            for (int i = 0; i < 16; i++) exp_mem[i] = 32'h0;
        end
    end

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        bit acc;
        int n = 0;
        wv = 1'b1; wa = a; wd = d; ws = s;
        do begin acc = wr; tick(); n++; end while (!acc && n < 100);
        if (!acc) check("write_timeout", {31'b0, wr}, 1);
        wv = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a);
        bit acc;
        int n = 0;
        rv = 1'b1; ra = a;
        do begin acc = rr; tick(); n++; end while (!acc && n < 100);
        if (!acc) check("read_timeout", {31'b0, rr}, 1);
    endtask

    task automatic drain();
        int n = 0;
        rv = 1'b0;
        while (exp_q.size() != 0 && n < 50) begin tick(); n++; end
        check("drain", 32'(exp_q.size()), 0);
    endtask

    task automatic sweep_len(input string tag, input int unsigned exp_len);
        int n = 0;
        while (busy && n < 100) begin tick(); n++; end
        check(tag, 32'(n), exp_len);
    endtask

    initial begin
        int n;
        #1 rst_n = 1'b0; b_rst_n = 1'b0;
        #1;
        check("rst_busy", {31'b0, busy}, 1);
        check("rst_wready", {31'b0, wr}, 0);
        check("rst_rready", {31'b0, rr}, 0);
        check("rst_rvalid", {31'b0, rdv}, 0);
        check("rst_rdata", rd, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        sweep_len("sweep_len", D);
        for (int a = 0; a < D; a++) do_read(4'(a));
        drain();

        // Strobed merge and latency
        do_write(4'd3, 32'hDEADBEEF, 4'b1111);
        do_write(4'd3, 32'h000000AA, 4'b0001);
        do_read(4'd3);
        rv = 1'b0;
        check("lat_early", {31'b0, rdv}, 0);
        tick();
        check("lat_ontime", {31'b0, rdv}, 1);
        drain();

        // Backpressure stall
        do_write(4'd1, 32'h1, 4'hF);
        do_write(4'd2, 32'h2, 4'hF);
        do_write(4'd3, 32'h3, 4'hF);
        rdr = 1'b0;
        do_read(4'd1);
        do_read(4'd2);
        ra = 4'd3;
        repeat (5) begin
            check("stall_rready", {31'b0, rr}, 0);
            check("stall_rvalid", {31'b0, rdv}, 1);
            check("stall_data", rd, 32'h1);
            tick();
        end
        rdr = 1'b1;
        do_read(4'd3);
        drain();

        // Same-cycle write/read collisions and empty strobe
        do_write(4'd5, 32'h22222222, 4'hF);
        wv = 1'b1; wa = 4'd5; wd = 32'h11111111; ws = 4'hF; rv = 1'b1; ra = 4'd5;
        tick();
        wd = 32'hAAAAAAAA; ws = 4'b0011;
        tick();
        wv = 1'b0; rv = 1'b0;
        do_write(4'd5, 32'hFFFFFFFF, 4'b0000);
        do_read(4'd5);
        drain();

        // Run-time clear with a stalled result draining mid-sweep and a redundant clear pulse
        for (int a = 0; a < D; a++) do_write(4'(a), 32'h10203040 + 32'(a) * 32'h01010101, 4'hF);
        rdr = 1'b0;
        do_read(4'd4);
        rv = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            check("clr_ready", {30'b0, wr, rr}, 0);
            clr = (n == 5);
            if (n >= 3) rdr = 1'b1;
            tick();
            n++;
        end
        clr = 1'b0; rdr = 1'b1;
        check("clr_len", 32'(n), D);
        for (int a = 0; a < D; a++) do_read(4'(a));
        drain();

        // Reset in the middle of a sweep with a result held in the pipeline
        rdr = 1'b0;
        do_read(4'd2);
        rv = 1'b0;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'b0, busy}, 1);
        check("mid_rst_wready", {31'b0, wr}, 0);
        check("mid_rst_rvalid", {31'b0, rdv}, 0);
        check("mid_rst_rdata", rd, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; rdr = 1'b1;
        sweep_len("mid_rst_sweep_len", D);
        check("mid_rst_flush", 32'(exp_q.size()), 0);

        // Out-of-range address on the non-power-of-2 array
        do_write(4'd13, 32'hFFFFFFFF, 4'hF);
        do_read(4'd13);
        for (int a = 0; a < D; a++) do_read(4'(a));
        do_read(4'd15);
        drain();

        // Second instance: DEPTH=16, single-stage read
        check("b_rst_busy", {31'b0, b_busy}, 1);
        check("b_rst_rvalid", {31'b0, b_rdv}, 0);
        @(posedge clk);
        #1 b_rst_n = 1'b1;
        n = 0;
        while (b_busy && n < 100) begin tick(); n++; end
        check("b_sweep_len", 32'(n), 16);
        b_wv = 1'b1; b_wa = 4'd3; b_wd = 32'hDEADBEEF; b_ws = 4'hF;
        check("b_wready", {31'b0, b_wr}, 1);
        tick();
        b_wd = 32'h000000AA; b_ws = 4'b0001;
        tick();
        b_wv = 1'b0; b_rv = 1'b1; b_ra = 4'd3;
        check("b_rready", {31'b0, b_rr}, 1);
        tick();
        b_ra = 4'd15;
        check("b_lat1_valid", {31'b0, b_rdv}, 1);
        check("b_lat1_data", b_rd, 32'hDEADBEAA);
        tick();
        b_rv = 1'b0;
        check("b_addr15_data", b_rd, 32'h0);
        check("b_addr15_valid", {31'b0, b_rdv}, 1);
        tick();
        check("b_empty_valid", {31'b0, b_rdv}, 0);
        check("b_empty_data", b_rd, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_sdp.md
Name: ram_sdp

Overview:
- Parametrised simple-dual-port RAM: one write port, one read port, valid/ready on both, byte-strobe writes.
- Read port has a configurable-latency read pipeline with consumer backpressure.
- After reset, a built-in clear engine sweeps the array to zero; the same sweep can be re-triggered at run time.
- General storage primitive for switch buffers: MAC table, frame descriptor store, packet buffer.

Parameters:
- WIDTH, 32, data word width in bits; must be a multiple of BYTE_WIDTH.
- DEPTH, 16, number of words; need not be a power of 2.
- BYTE_WIDTH, 8, bits per write-strobe lane.
- READ_LATENCY, 1, cycles from read acceptance to read_data_valid; legal values 1 or 2.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous reset, active-low.
- clear_start  in  1  one-cycle pulse; starts a zero sweep of the whole array.
- clear_busy  out  1  high while the sweep runs.
- write_valid  in  1  write request.
- write_ready  out  1  write accepted when valid && ready.
- write_address  in  $clog2(DEPTH)  write word address.
- write_data  in  WIDTH  write word.
- write_strobe  in  WIDTH/BYTE_WIDTH  per-lane write enable.
- read_valid  in  1  read request.
- read_ready  out  1  read accepted when valid && ready.
- read_address  in  $clog2(DEPTH)  read word address.
- read_data_valid  out  1  read_data holds a result.
- read_data  out  WIDTH  read result.
- read_data_ready  in  1  consumer takes the result when read_data_valid && read_data_ready.

Behaviour:
- Reset (reset_n low), all outputs asynchronously:
  - read_data_valid=0, read_data=0, read_ready=0, write_ready=0.
  - clear_busy=1; FSM state CLEAR; sweep counter=0.
- The storage array itself is never reset directly. It is zeroed only by the sweep.
- FSM has two states, CLEAR and IDLE.
  - CLEAR: write word 0 to address counter each cycle; counter increments. At counter==DEPTH-1 the write completes, next state is IDLE and clear_busy drops. Sweep takes exactly DEPTH cycles after reset release.
  - IDLE -> CLEAR on clear_start. clear_start is ignored while already in CLEAR.
  - reset_n asserted mid-sweep: counter restarts from 0.
- In CLEAR, write_ready=0 and read_ready=0.
  - Read pipeline contents still drain, and read_data_ready is still honoured.
- Write, in IDLE:
  - write_ready=1.
  - On accept, lanes with a strobe bit of 1 are updated at the clock edge; other lanes keep their value.
  - write_strobe all zero: accepted, no change.
  - write_address >= DEPTH: accepted and discarded.
- Read pipeline:
  - READ_LATENCY stages, each a valid bit plus data; the last stage drives read_data_valid/read_data.
  - advance = !(read_data_valid && !read_data_ready). When advance is high every stage shifts by one.
  - Stall: with advance low, all stages hold and read_data stays stable.
  - read_ready = (state==IDLE) && advance.
  - Latency: accepted at edge N -> read_data_valid at edge N+READ_LATENCY-1 (visible in the cycle after that edge), provided there is no stall.
  - Back-to-back reads sustain one per cycle while read_data_ready=1.
  - read_address >= DEPTH returns 0.
- Empty last stage: read_data is driven to 0, never high-impedance.
- Same-cycle write and read to the same address: governed by RAM_BYPASS_EN (see Optional Feature).
- Same-cycle clear_start with an accepted read or write: the access completes first; CLEAR begins next cycle.

Optional Feature:
- Macro: RAM_BYPASS_EN.
- Defined (write-first): a read accepted in the same cycle as a write to the same address returns the new data for strobed lanes and the old data for unstrobed lanes.
- Undefined (read-first): such a read returns the pre-write word in full.
- All other behaviour is identical with or without the macro.

Test Plan:
- Release reset with DEPTH=16, then poll clear_busy -> high for exactly 16 cycles. Read all 16 addresses -> every word 0.
- Write 0xDEADBEEF to addr 3 with strobe 4'b1111. Then write 0x000000AA to addr 3 with strobe 4'b0001. Read addr 3 -> 0xDEADBEAA, valid at cycle N+READ_LATENCY.
- Hold read_data_ready=0 for 5 cycles during back-to-back reads of addr 1,2,3 (READ_LATENCY=2). Expect:
  - read_ready low while stalled.
  - read_data stable.
  - Results 1,2,3 delivered in order with none lost or duplicated.
- Same-cycle write 0x11111111 and read of addr 5 (old value 0x22222222) -> 0x11111111 with RAM_BYPASS_EN, 0x22222222 without.
- Pulse clear_start after filling memory. Expect:
  - write_ready and read_ready low for DEPTH cycles.
  - Subsequent reads of every address return 0.
- Assert reset_n low at sweep cycle 7, release -> clear_busy high for a full DEPTH cycles again and outputs reset immediately; DEPTH=12 (non-power-of-2): write to addr 13 discarded, read of addr 13 returns 0.
